// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply sequencer.
package mult_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_sign_cond.sv
// Conditional two's-complement negation: o_value = i_neg ? -i_value : i_value.
module mult_sign_cond #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_value,
  input  logic         i_neg,
  output logic [W-1:0] o_value
);

  logic [W-1:0] w_negated;

  assign w_negated = ~i_value + W'(1);
  assign o_value   = i_neg ? w_negated : i_value;

endmodule

// File: rtl/mult_hilo_seq.sv
// Multiply sequencer: feeds operand magnitudes to an external combinational
// multiplier core, waits LAT cycles, sign-corrects the product into HI/LO.
//
//   state | meaning
//   IDLE  | waiting for start; mthi/mtlo accepted
//   WAIT  | core inputs held, counter running down to the sample point
//   FIX   | captured product sign-corrected and written to HI/LO
module mult_hilo_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LAT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   mc_o,
  output logic [WIDTH-1:0]   mp_o,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_t               r_state;
  state_t               w_state_nx;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_fix;
  logic                 w_cnt_zero;

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_mc;
  logic [WIDTH-1:0]     r_mp;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_prod;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_mc_mag;
  logic [WIDTH-1:0]     w_mp_mag;
  logic [2*WIDTH-1:0]   w_prod_fix;

  assign w_a_neg    = is_signed & op_a[WIDTH-1];
  assign w_b_neg    = is_signed & op_b[WIDTH-1];
  assign w_cnt_zero = (r_cnt == '0);

  mult_sign_cond #(.W(WIDTH)) u_cond_a (
    .i_value (op_a),
    .i_neg   (w_a_neg),
    .o_value (w_mc_mag)
  );

  mult_sign_cond #(.W(WIDTH)) u_cond_b (
    .i_value (op_b),
    .i_neg   (w_b_neg),
    .o_value (w_mp_mag)
  );

  mult_sign_cond #(.W(2*WIDTH)) u_cond_p (
    .i_value (r_prod),
    .i_neg   (r_neg),
    .o_value (w_prod_fix)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_fix      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = WAIT;
        end
      end
      WAIT: begin
        if (w_cnt_zero) begin
          w_capture  = 1'b1;
          w_state_nx = FIX;
        end
      end
      FIX: begin
        w_fix      = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Operand latch, sign flag, settle counter and product capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mc   <= '0;
      r_mp   <= '0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else begin
      if (w_accept) begin
        r_mc  <= w_mc_mag;
        r_mp  <= w_mp_mag;
        r_neg <= w_a_neg ^ w_b_neg;
        r_cnt <= CNT_W'(LAT - 1);
      end else if (r_state == WAIT && !w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) r_prod <= prod_i;
    end
  end

  // Handshake flags: busy spans accept..write, done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_accept)   r_busy <= 1'b1;
      else if (w_fix) r_busy <= 1'b0;
    end
  end

  // HI/LO: a completing multiply takes priority over mthi/mtlo on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix) begin
      r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
      r_lo <= w_prod_fix[WIDTH-1:0];
    end else begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  assign mc_o = r_mc;
  assign mp_o = r_mp;
  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_hilo_seq.sv
// Directed bench for mult_hilo_seq with a behavioural combinational core.
module tb_mult_hilo_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mc_o;
  logic [31:0] mp_o;
  logic [63:0] prod_i;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  mult_hilo_seq #(.WIDTH(32), .LAT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .mc_o      (mc_o),
    .mp_o      (mp_o),
    .prod_i    (prod_i),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  assign prod_i = {32'd0, mc_o} * {32'd0, mp_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mc;
    logic [31:0] mp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one multiply; returns cycles from start edge to done and busy-high cycle count.
  task automatic do_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_cyc = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  int lat, bcyc, dcount;

  initial begin
    vecs[0] = '{1'b0, 32'd3,          32'd5,          32'h00000000, 32'h0000000F, 32'd3,          32'd5};
    vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF,   32'hFFFFFFFF};
    vecs[2] = '{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,          32'd1};
    vecs[3] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001, 32'd1,          32'd1};
    vecs[4] = '{1'b1, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000, 32'h80000000,   32'h80000000};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFFFFFD,   32'hFFFFFFFF, 32'hFFFFFFEB, 32'd7,          32'd3};
    vecs[6] = '{1'b0, 32'h00010000,   32'h00010000,   32'h00000001, 32'h00000000, 32'h00010000,   32'h00010000};
    vecs[7] = '{1'b1, 32'd0,          32'hFFFFFFFB,   32'h00000000, 32'h00000000, 32'd0,          32'd5};

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #23;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_mcmp", {mc_o, mp_o}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_mult(vecs[i].s, vecs[i].a, vecs[i].b, lat, bcyc);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bcyc), 64'd5);
      chk($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
      chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_mc", i), {32'd0, mc_o}, {32'd0, vecs[i].mc});
      chk($sformatf("v%0d_mp", i), {32'd0, mp_o}, {32'd0, vecs[i].mp});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_one_cycle", i), {63'd0, done}, 64'd0);
    end

    // Second start two cycles into a multiply is dropped.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (k == 2) begin
        start = 1'b1; op_a = 32'd7; op_b = 32'd9;
      end
      if (k == 3) start = 1'b0;
    end
    chk("ignored_start_done_count", 64'(dcount), 64'd1);
    chk("ignored_start_lo", {32'd0, lo}, 64'd15);
    chk("ignored_start_mc", {32'd0, mc_o}, 64'd3);

    // mthi then mtlo in IDLE.
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk); hi_we = 1'b0;
    chk("mthi_hi", {32'd0, hi}, 64'h1234);
    chk("mthi_lo_kept", {32'd0, lo}, 64'd15);
    lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk); lo_we = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, 64'hABCD);
    chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234);

    // Reset during WAIT aborts the multiply.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_busy", {63'd0, busy}, 64'd0);
    chk("rst_wait_done", {63'd0, done}, 64'd0);
    chk("rst_wait_hilo", {hi, lo}, 64'd0);
    chk("rst_wait_mcmp", {mc_o, mp_o}, 64'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("rst_wait_no_done", 64'(dcount), 64'd0);
    do_mult(1'b0, 32'd6, 32'd7, lat, bcyc);
    chk("post_rst_latency", 64'(lat), 64'd5);
    chk("post_rst_result", {hi, lo}, 64'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
